// File: rtl/tcp_app_buf_tracker_if.sv
// tcp_app_buf_tracker_if
// Handshake bundle between the TCP RX engine, the application tiles and the
// buffer tracker.
//   commit_*  RX engine -> tracker : bytes written into a flow's ring
//   req_*     app       -> tracker : message request (flow, max length)
//   resp_*    tracker   -> app     : buffer descriptor (single entry)
//   adj_*     app       -> tracker : bytes consumed and released
// Modports: master = RX engine / application side, slave = tracker.
interface tcp_app_buf_tracker_if #(
    parameter int NUM_FLOWS = 8,
    parameter int BUF_W     = 12,
    parameter int PTR_W     = 32,
    parameter int IDX_W     = 8
);
    localparam int FLOWID_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;

    logic                commit_val;
    logic                commit_rdy;
    logic [FLOWID_W-1:0] commit_flowid;
    logic [BUF_W:0]      commit_bytes;

    logic                req_val;
    logic                req_rdy;
    logic [FLOWID_W-1:0] req_flowid;
    logic [PTR_W:0]      req_len;

    logic                resp_val;
    logic                resp_rdy;
    logic [FLOWID_W-1:0] resp_flowid;
    logic [PTR_W-1:0]    resp_bufptr;
    logic [IDX_W:0]      resp_idx;
    logic [PTR_W:0]      resp_len;
    logic [PTR_W:0]      resp_cap;

    logic                adj_val;
    logic                adj_rdy;
    logic [FLOWID_W-1:0] adj_flowid;
    logic [PTR_W:0]      adj_bytes;

    modport master (
        output commit_val, commit_flowid, commit_bytes,
        input  commit_rdy,
        output req_val, req_flowid, req_len,
        input  req_rdy,
        input  resp_val, resp_flowid, resp_bufptr, resp_idx, resp_len, resp_cap,
        output resp_rdy,
        output adj_val, adj_flowid, adj_bytes,
        input  adj_rdy
    );

    modport slave (
        input  commit_val, commit_flowid, commit_bytes,
        output commit_rdy,
        input  req_val, req_flowid, req_len,
        output req_rdy,
        output resp_val, resp_flowid, resp_bufptr, resp_idx, resp_len, resp_cap,
        input  resp_rdy,
        input  adj_val, adj_flowid, adj_bytes,
        output adj_rdy
    );
endinterface

// File: rtl/tcp_app_buf_tracker.sv
// tcp_app_buf_tracker
// Per-flow receive ring tracker. Holds tail (committed), gnt (handed to the
// application) and head (released) pointers per flow, answers requests with
// buffer descriptors, parks requests on empty flows and serves them when data
// arrives, and flags overflowing commits and over-consuming adjusts.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       commit / req / resp / adj handshakes
//   err_overflow      one-cycle pulse, commit larger than free space
//   err_overconsume   one-cycle pulse, adjust larger than granted bytes
module tcp_app_buf_tracker #(
    parameter int          NUM_FLOWS = 8,
    parameter int          BUF_W     = 12,
    parameter int          PTR_W     = 32,
    parameter int          IDX_W     = 8,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tcp_app_buf_tracker_if.slave bus,
    output logic                 err_overflow,
    output logic                 err_overconsume
);
    localparam int FLOWID_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;
    localparam int P_W      = BUF_W + 1;
    localparam int L_W      = PTR_W + 1;
    localparam logic [P_W-1:0] BUF_SIZE = {1'b1, {BUF_W{1'b0}}};

    logic [P_W-1:0]   tail_q     [NUM_FLOWS];
    logic [P_W-1:0]   gnt_q      [NUM_FLOWS];
    logic [P_W-1:0]   head_q     [NUM_FLOWS];
    logic [IDX_W:0]   idx_q      [NUM_FLOWS];
    logic             pend_q     [NUM_FLOWS];
    logic [L_W-1:0]   pend_len_q [NUM_FLOWS];

    // Lowest-numbered parked flow that now has ungranted data.
    logic                svc_hit;
    logic [FLOWID_W-1:0] svc_flow;

    always_comb begin
        svc_hit  = 1'b0;
        svc_flow = '0;
        for (int f = NUM_FLOWS - 1; f >= 0; f--) begin
            if (pend_q[f] && (tail_q[f] != gnt_q[f])) begin
                svc_hit  = 1'b1;
                svc_flow = FLOWID_W'(f);
            end
        end
    end

    logic resp_free;
    logic adj_fire, commit_fire, svc_fire, req_fire;

    assign resp_free   = !bus.resp_val || bus.resp_rdy;
    assign bus.adj_rdy    = 1'b1;
    assign bus.commit_rdy = !bus.adj_val;
    assign bus.req_rdy    = resp_free && !bus.adj_val && !bus.commit_val && !svc_hit;

    assign adj_fire    = bus.adj_val;
    assign commit_fire = bus.commit_val && !bus.adj_val;
    assign svc_fire    = svc_hit && resp_free && !bus.adj_val && !bus.commit_val;
    assign req_fire    = bus.req_val && bus.req_rdy;

    // Grant datapath, shared by pending-service and fresh requests. The grant
    // is clipped at the end of the ring so a descriptor is always contiguous.
    logic [FLOWID_W-1:0] g_flow;
    logic [L_W-1:0]      g_lim;
    logic [P_W-1:0]      g_ungr;
    logic [BUF_W-1:0]    g_off;
    logic [P_W-1:0]      g_to_end;
    logic [P_W-1:0]      g_cap;
    logic [P_W-1:0]      g_len;
    logic                grant_go;
    logic                park;

    always_comb begin
        g_flow   = svc_fire ? svc_flow : bus.req_flowid;
        g_lim    = svc_fire ? pend_len_q[svc_flow] : bus.req_len;
        g_ungr   = tail_q[g_flow] - gnt_q[g_flow];
        g_off    = gnt_q[g_flow][BUF_W-1:0];
        g_to_end = BUF_SIZE - {1'b0, g_off};
        g_cap    = (g_ungr < g_to_end) ? g_ungr : g_to_end;
        g_len    = (g_lim < L_W'(g_cap)) ? g_lim[P_W-1:0] : g_cap;
    end

    assign grant_go = svc_fire || (req_fire && (g_ungr != '0));
    assign park     = req_fire && (g_ungr == '0);

    logic [P_W-1:0] c_free;
    logic           commit_ok;
    logic [P_W-1:0] a_granted;
    logic           adj_ok;

    always_comb begin
        c_free    = BUF_SIZE - (tail_q[bus.commit_flowid] - head_q[bus.commit_flowid]);
        commit_ok = (bus.commit_bytes <= c_free);
        a_granted = gnt_q[bus.adj_flowid] - head_q[bus.adj_flowid];
        adj_ok    = (bus.adj_bytes <= L_W'(a_granted));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < NUM_FLOWS; f++) begin
                tail_q[f]     <= '0;
                gnt_q[f]      <= '0;
                head_q[f]     <= '0;
                idx_q[f]      <= '0;
                pend_q[f]     <= 1'b0;
                pend_len_q[f] <= '0;
            end
            bus.resp_val    <= 1'b0;
            bus.resp_flowid <= '0;
            bus.resp_bufptr <= '0;
            bus.resp_idx    <= '0;
            bus.resp_len    <= '0;
            bus.resp_cap    <= '0;
            err_overflow    <= 1'b0;
            err_overconsume <= 1'b0;
        end else begin
            err_overflow    <= 1'b0;
            err_overconsume <= 1'b0;

            if (adj_fire) begin
                if (adj_ok) begin
                    head_q[bus.adj_flowid] <= head_q[bus.adj_flowid] + bus.adj_bytes[P_W-1:0];
                end else begin
                    err_overconsume <= 1'b1;
                end
            end

            if (commit_fire) begin
                if (commit_ok) begin
                    tail_q[bus.commit_flowid] <= tail_q[bus.commit_flowid] + bus.commit_bytes;
                end else begin
                    err_overflow <= 1'b1;
                end
            end

            if (park) begin
                pend_q[g_flow]     <= 1'b1;
                pend_len_q[g_flow] <= bus.req_len;
            end

            if (grant_go) begin
                bus.resp_val    <= 1'b1;
                bus.resp_flowid <= g_flow;
                bus.resp_bufptr <= PTR_W'(BASE_ADDR) + (PTR_W'(g_flow) << BUF_W) + PTR_W'(g_off);
                bus.resp_idx    <= idx_q[g_flow];
                bus.resp_len    <= L_W'(g_len);
                bus.resp_cap    <= L_W'(BUF_SIZE);
                gnt_q[g_flow]   <= gnt_q[g_flow] + g_len;
                idx_q[g_flow]   <= idx_q[g_flow] + (IDX_W + 1)'(1);
                if (svc_fire) begin
                    pend_q[g_flow] <= 1'b0;
                end
            end else if (bus.resp_rdy) begin
                bus.resp_val <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tcp_app_buf_tracker.sv
module tb_tcp_app_buf_tracker;
    localparam int     NF = 8;
    localparam int     BW = 12;
    localparam int     PW = 32;
    localparam int     IW = 8;
    localparam longint BS = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_overflow;
    logic err_overconsume;

    int n_checks = 0;
    int n_fail   = 0;

    tcp_app_buf_tracker_if #(.NUM_FLOWS(NF), .BUF_W(BW), .PTR_W(PW), .IDX_W(IW)) bus ();

    tcp_app_buf_tracker #(
        .NUM_FLOWS(NF), .BUF_W(BW), .PTR_W(PW), .IDX_W(IW), .BASE_ADDR(64'd0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .err_overflow(err_overflow),
        .err_overconsume(err_overconsume)
    );

    always #5 clk = ~clk;

    // Reference model: byte counts that only grow, ring positions derived by modulo.
    longint prod [NF];
    longint gtd  [NF];
    longint cons [NF];
    longint m_idx[NF];
    longint plen [NF];
    bit     pend [NF];

    task automatic model_reset();
        for (int f = 0; f < NF; f++) begin
            prod[f] = 0; gtd[f] = 0; cons[f] = 0; m_idx[f] = 0; plen[f] = 0; pend[f] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_grant(input int f, input longint lim,
                           output longint ptr, output longint len, output longint iv);
        longint off;
        longint avail;
        off   = gtd[f] % BS;
        avail = prod[f] - gtd[f];
        len   = lim;
        if (avail < len) len = avail;
        if (BS - off < len) len = BS - off;
        ptr   = f * BS + off;
        iv    = m_idx[f] % 512;
        gtd[f]   += len;
        m_idx[f] += 1;
    endtask

    task automatic expect_resp(input int f, input longint ptr, input longint len, input longint iv);
        chk("resp_val", bus.resp_val, 1);
        chk("resp_flowid", bus.resp_flowid, f);
        chk("resp_bufptr", bus.resp_bufptr, ptr);
        chk("resp_idx", bus.resp_idx, iv);
        chk("resp_len", bus.resp_len, len);
        chk("resp_cap", bus.resp_cap, BS);
    endtask

    task automatic op_commit(input int f, input longint b);
        bit ovf;
        longint ptr, len, iv;
        bus.commit_val = 1'b1; bus.commit_flowid = 3'(f); bus.commit_bytes = 13'(b);
        #1;
        chk("commit_rdy", bus.commit_rdy, 1);
        @(posedge clk); #1;
        bus.commit_val = 1'b0;
        ovf = (b > BS - (prod[f] - cons[f]));
        if (!ovf) prod[f] += b;
        chk("err_overflow", err_overflow, ovf);
        chk("err_overconsume_c", err_overconsume, 0);
        chk("resp_val_commit", bus.resp_val, 0);
        @(posedge clk); #1;
        chk("err_overflow_width", err_overflow, 0);
        if (pend[f] && prod[f] > gtd[f]) begin
            pend[f] = 0;
            m_grant(f, plen[f], ptr, len, iv);
            expect_resp(f, ptr, len, iv);
        end else begin
            chk("resp_val_idle", bus.resp_val, 0);
        end
    endtask

    task automatic op_req(input int f, input longint lim, input longint c_len, input longint c_ptr);
        longint ptr, len, iv;
        bus.req_val = 1'b1; bus.req_flowid = 3'(f); bus.req_len = 33'(lim);
        #1;
        chk("req_rdy", bus.req_rdy, 1);
        @(posedge clk); #1;
        bus.req_val = 1'b0;
        if (prod[f] == gtd[f]) begin
            pend[f] = 1; plen[f] = lim;
            chk("resp_val_park", bus.resp_val, 0);
        end else begin
            m_grant(f, lim, ptr, len, iv);
            expect_resp(f, ptr, len, iv);
            if (c_len >= 0) chk("tp_len", bus.resp_len, c_len);
            if (c_ptr >= 0) chk("tp_bufptr", bus.resp_bufptr, c_ptr);
        end
        chk("err_overflow_r", err_overflow, 0);
        chk("err_overconsume_r", err_overconsume, 0);
    endtask

    task automatic op_adj(input int f, input longint b);
        bit oc;
        bus.adj_val = 1'b1; bus.adj_flowid = 3'(f); bus.adj_bytes = 33'(b);
        #1;
        chk("adj_rdy", bus.adj_rdy, 1);
        @(posedge clk); #1;
        bus.adj_val = 1'b0;
        oc = (b > gtd[f] - cons[f]);
        if (!oc) cons[f] += b;
        chk("err_overconsume", err_overconsume, oc);
        chk("err_overflow_a", err_overflow, 0);
        @(posedge clk); #1;
        chk("err_overconsume_width", err_overconsume, 0);
        chk("resp_val_adj", bus.resp_val, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        longint ptr, len, iv, g, b;
        int op, f;
        bus.commit_val = 0; bus.commit_flowid = 0; bus.commit_bytes = 0;
        bus.req_val = 0; bus.req_flowid = 0; bus.req_len = 0;
        bus.resp_rdy = 1;
        bus.adj_val = 0; bus.adj_flowid = 0; bus.adj_bytes = 0;
        model_reset();

        #3;
        chk("rst_resp_val", bus.resp_val, 0);
        chk("rst_resp_len", bus.resp_len, 0);
        chk("rst_resp_bufptr", bus.resp_bufptr, 0);
        chk("rst_resp_cap", bus.resp_cap, 0);
        chk("rst_err_overflow", err_overflow, 0);
        chk("rst_err_overconsume", err_overconsume, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rdy_adj_idle", bus.adj_rdy, 1);
        chk("rdy_commit_idle", bus.commit_rdy, 1);
        chk("rdy_req_idle", bus.req_rdy, 1);
        @(posedge clk); #1;

        // Basic grants on flow 0
        op_commit(0, 100);
        op_req(0, 64, 64, 0);
        chk("tp_idx0", bus.resp_idx, 0);
        op_req(0, 64, 36, 64);
        chk("tp_idx1", bus.resp_idx, 1);

        // Ring wrap on flow 3
        op_commit(3, 4000);
        op_req(3, 4000, 4000, 3 * 4096);
        op_adj(3, 4000);
        op_commit(3, 200);
        op_req(3, 200, 96, 3 * 4096 + 4000);
        op_req(3, 200, 104, 3 * 4096);

        // Parked request on flow 2
        op_req(2, 50, -1, -1);
        op_commit(2, 20);
        chk("tp_pend_val", bus.resp_val, 1);
        chk("tp_pend_len", bus.resp_len, 20);
        op_commit(2, 30);
        op_req(2, 100, 30, 2 * 4096 + 20);

        // Errors on flow 1
        op_commit(1, 4096);
        op_commit(1, 1);
        op_adj(1, 10);
        op_req(1, 5000, 4096, 4096);

        // Arbitration
        bus.adj_val = 1; bus.adj_flowid = 0; bus.adj_bytes = 0;
        bus.commit_val = 1; bus.commit_flowid = 7; bus.commit_bytes = 0;
        bus.req_val = 1; bus.req_flowid = 7; bus.req_len = 10;
        #1;
        chk("arb_adj_rdy", bus.adj_rdy, 1);
        chk("arb_commit_rdy", bus.commit_rdy, 0);
        chk("arb_req_rdy", bus.req_rdy, 0);
        @(posedge clk); #1;
        bus.adj_val = 0;
        #1;
        chk("arb2_commit_rdy", bus.commit_rdy, 1);
        chk("arb2_req_rdy", bus.req_rdy, 0);
        bus.commit_val = 0; bus.req_val = 0;
        @(posedge clk); #1;
        chk("arb_no_err", err_overflow | err_overconsume, 0);
        chk("arb_no_resp", bus.resp_val, 0);

        // Backpressure on flow 0
        op_commit(0, 300);
        bus.resp_rdy = 0;
        op_req(0, 10, 10, 100);
        bus.req_val = 1; bus.req_flowid = 0; bus.req_len = 20;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_req_rdy", bus.req_rdy, 0);
            chk("bp_hold_len", bus.resp_len, 10);
            chk("bp_hold_ptr", bus.resp_bufptr, 100);
            @(posedge clk); #1;
        end
        bus.resp_rdy = 1;
        #1;
        chk("bp_release_rdy", bus.req_rdy, 1);
        @(posedge clk); #1;
        bus.req_val = 0;
        m_grant(0, 20, ptr, len, iv);
        expect_resp(0, ptr, len, iv);
        @(posedge clk); #1;
        chk("bp_drained", bus.resp_val, 0);

        // Reset with a response in flight and flows 4/5 parked
        op_req(4, 30, -1, -1);
        op_req(5, 30, -1, -1);
        bus.resp_rdy = 0;
        op_req(0, 5, 5, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_val", bus.resp_val, 0);
        chk("mid_rst_resp_len", bus.resp_len, 0);
        model_reset();
        bus.resp_rdy = 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op_commit(4, 8);
        chk("rst_pend_dropped", bus.resp_val, 0);
        op_req(5, 30, -1, -1);
        chk("rst_repark", bus.resp_val, 0);
        op_commit(5, 12);
        chk("rst_serve_len", bus.resp_len, 12);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 2));
            f  = int'($urandom_range(0, NF - 1));
            if (op == 0) begin
                if ($urandom_range(0, 9) == 0) b = longint'($urandom_range(0, 8191));
                else b = longint'($urandom_range(0, 1500));
                op_commit(f, b);
            end else if (op == 1) begin
                op_req(f, longint'($urandom_range(0, 3000)), -1, -1);
            end else begin
                g = gtd[f] - cons[f];
                if ($urandom_range(0, 7) == 0) b = g + longint'($urandom_range(1, 50));
                else b = longint'($urandom_range(0, int'(g)));
                op_adj(f, b);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tcp_app_buf_tracker.md
# tcp_app_buf_tracker

Per-flow receive-buffer pointer tracker between the TCP RX engine and application tiles. It holds producer (tail), grant and consumer (head) pointers for NUM_FLOWS ring buffers, each 2^BUF_W bytes. It answers application message requests with buffer descriptors carrying bufptr, idx, len and cap, and it retires consumed bytes on adjust messages. It generalises the fixed single-format tcp_buf_info/tcp_adjust_idx exchange with these additions:

- parametrised flow count, buffer size and index widths;
- ring wrap-around handling;
- parked (pending) requests that are served when data arrives;
- overflow and over-consume error detection.

## Interface
Parameters:
- NUM_FLOWS, 8, number of tracked flows; FLOWID_W = $clog2(NUM_FLOWS)
- BUF_W, 12, log2 of per-flow buffer bytes; BUF_SIZE = 2^BUF_W
- PTR_W, 32, byte address width (matches MAX_PAYLOAD_PTR_W)
- IDX_W, 8, grant index width; the index carries an extra wrap bit
- BASE_ADDR, 0, address of flow 0's buffer; flow f region = BASE_ADDR + f*BUF_SIZE

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- commit_val / commit_rdy  in/out  1/1  RX engine has written bytes into the buffer
- commit_flowid  in  FLOWID_W;  commit_bytes  in  BUF_W+1
- req_val / req_rdy  in/out  1/1  application message request
- req_flowid  in  FLOWID_W;  req_len  in  PTR_W+1
- resp_val / resp_rdy  out/in  1/1  descriptor response
- resp_flowid  out  FLOWID_W;  resp_bufptr  out  PTR_W;  resp_idx  out  IDX_W+1;  resp_len  out  PTR_W+1;  resp_cap  out  PTR_W+1
- adj_val / adj_rdy  in/out  1/1  application consumed bytes
- adj_flowid  in  FLOWID_W;  adj_bytes  in  PTR_W+1
- err_overflow  out  1  one-cycle pulse: commit exceeded free space
- err_overconsume  out  1  one-cycle pulse: adjust exceeded granted bytes

## Operation
Per-flow state is held in flops. All pointers are BUF_W+1 bits; the top bit is the wrap bit.
- Pointers:
  - tail: advanced by commit.
  - gnt: advanced by grants.
  - head: advanced by adjust.
  - Invariant: head ≤ gnt ≤ tail, with the distance between head and tail ≤ BUF_SIZE.
- Per-flow control state:
  - idx: IDX_W+1 bits; increments, wrapping, on every grant.
  - pend bit and pend_len: PTR_W+1 bits.
- Derived quantities, computed mod 2^(BUF_W+1):
  - ungranted = tail − gnt
  - granted = gnt − head
  - free = BUF_SIZE − (tail − head)
- One operation executes per cycle. Fixed priority is adjust > commit > pending-service > request. A lower-priority rdy is low whenever a higher-priority operation is valid.
- **Commit:**
  - If commit_bytes ≤ free: tail += commit_bytes.
  - Otherwise: pulse err_overflow and leave state unchanged.
  - commit_bytes = 0 is a legal no-op.
- **Request:**
  - req_rdy = 1 only when the response register is empty, or is draining this cycle (resp_val & resp_rdy), and no higher-priority operation is valid.
  - If ungranted = 0: set pend and store pend_len = req_len. No response is produced.
  - If the flow already has pend = 1, the new request overwrites pend_len.
- **Grant** (from a request or a pending-service):
  - len = min(L, ungranted, BUF_SIZE − gnt[BUF_W-1:0]). A grant never crosses the buffer end.
  - Load the response register with:
    - resp_bufptr = BASE_ADDR + flowid*BUF_SIZE + gnt[BUF_W-1:0]
    - resp_idx = idx
    - resp_len = len
    - resp_cap = BUF_SIZE
  - Then gnt += len and idx += 1.
  - req_len = 0 produces a response with len = 0; gnt is unchanged and idx still increments.
- **Pending-service:** scans for the lowest flowid with pend = 1 and ungranted > 0. It grants with L = pend_len, clears pend, and needs the response register free.
- **Adjust:**
  - If adj_bytes ≤ granted: head += adj_bytes.
  - Otherwise: pulse err_overconsume and leave state unchanged.
- The response register is a single entry. It holds stable while resp_val & !resp_rdy.

## Timing
- Reset: all pointers, idx, pend = 0; resp_val = 0, err_* = 0, resp_* data = 0.
- Ready signals are combinational. After reset, req_rdy, commit_rdy and adj_rdy are 1 when no competing valid is present.
- Request accepted in cycle t → resp_val = 1 in cycle t+1.
- Commit in cycle t to a flow with pend = 1 → tail is visible at t+1, pending-service runs at t+1 if it wins arbitration and the response register is free → resp_val at t+2.
- Back-to-back requests with resp_rdy held high: one response per cycle.
- Error pulses assert in the cycle after the offending handshake, for exactly one cycle.
- Reset asserted mid-operation drops the response in flight and any pending requests, with no further output.

## Test plan
- Reset, then on flow 0: commit 100, request 64 → resp bufptr = 0, idx = 0, len = 64, cap = 4096. Request 64 again → bufptr = 64, idx = 1, len = 36.
- Wrap: on flow 3, commit 4000, request 4000, adjust 4000, commit 200, request 200 → len = 96, bufptr = 3*4096 + 4000. Next request → len = 104, bufptr = 3*4096.
- Pending: on flow 2, request 50 with the buffer empty → no resp. Commit 20 → resp len = 20 at commit cycle + 2, and pend is cleared.
- Errors: on flow 1, commit 4096 succeeds; commit 1 → err_overflow pulse and tail unchanged. Adjust 10 with granted = 0 → err_overconsume pulse.
- Arbitration and backpressure: drive adj, commit and req valid in the same cycle → only adj_rdy = 1. Hold resp_rdy = 0 → req_rdy = 0 and the response stays stable until released.
- Reset mid-stream with resp_val = 1 → resp_val drops asynchronously. After release, a request on the previously pending flow parks again.
